div_seq: RTL and testbench

Parametrised multi-cycle restoring divider for the CPU datapath's HI/LO unit, and the successor to the fixed 32-bit divider. It computes quotient into `lo` and remainder into `hi` for signed (DIV) or unsigned (DIVU) operands of configurable width. It also provides an explicit start/busy/done handshake, so the control FSM can stall on `busy` instead of counting cycles.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_restore_step.sv | 19 +
 rtl/div_seq.sv | 128 ++++++++++++
 tb/tb_div_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and width default for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step (shift in a bit, trial subtract)
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             num_bit,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted remainder carries one extra bit so the compare against den never wraps.
  logic [WIDTH:0] shifted;

  assign shifted = {rem_in, num_bit};
  assign q_bit   = (shifted >= {1'b0, den});
  assign rem_out = q_bit ? (shifted[WIDTH-1:0] - den) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider with start/busy/done handshake; DIV_SIGNED_EN enables signed DIV
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] num, den, quo, rem;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, zero_start;

  assign accept     = (state == IDLE) && start && (srcB != '0);
  assign zero_start = (state == IDLE) && start && (srcB == '0);

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, q_neg, r_neg;
  assign a_neg = signed_op & srcA[WIDTH-1];
  assign b_neg = signed_op & srcB[WIDTH-1];
  assign a_mag = a_neg ? (~srcA + 1'b1) : srcA;
  assign b_mag = b_neg ? (~srcB + 1'b1) : srcB;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_mag = srcA;
  assign b_mag = srcB;
`endif

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .num_bit (num[WIDTH-1]),
    .den     (den),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      num     <= '0;
      den     <= '0;
      quo     <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef DIV_SIGNED_EN
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (zero_start) begin
            divZero <= 1'b1;
            done    <= 1'b1;
          end else if (accept) begin
            num     <= a_mag;
            den     <= b_mag;
            quo     <= '0;
            rem     <= '0;
            cnt     <= CW'(WIDTH - 1);
            divZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
`endif
          end
        end
        RUN: begin
          // Dividend is shifted left so its MSB is always the next bit to bring down.
          rem <= rem_step;
          quo <= {quo[WIDTH-2:0], q_bit};
          num <= {num[WIDTH-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          lo <= q_neg ? (~quo + 1'b1) : quo;
          hi <= r_neg ? (~rem + 1'b1) : rem;
`else
          lo <= quo;
          hi <= rem;
`endif
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq at WIDTH=32 and WIDTH=8
module tb_div_seq;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start32, sop32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sop8, busy8, done8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signed_op(sop32),
    .srcA(a32), .srcB(b32), .busy(busy32), .done(done32),
    .divZero(dz32), .hi(hi32), .lo(lo32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(sop8),
    .srcA(a8), .srcB(b8), .busy(busy8), .done(done8),
    .divZero(dz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division built from magnitudes and the native / and % operators.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t e;
    logic [63:0] mask, ma, mb, q, r;
    logic an, bn;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    an = SIGNED_EN & s & a[w-1];
    bn = SIGNED_EN & s & b[w-1];
    ma = an ? ((~a + 64'd1) & mask) : (a & mask);
    mb = bn ? ((~b + 64'd1) & mask) : (b & mask);
    q = ma / mb;
    r = ma % mb;
    if (an ^ bn) q = (~q + 64'd1) & mask;
    if (an)      r = (~r + 64'd1) & mask;
    e.lo = q;
    e.hi = r;
    return e;
  endfunction

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    a32 = a; b32 = b; sop32 = s; start32 = 1'b1;
    if (b != 32'd0) sbq.push_back(model(32, {32'd0, a}, {32'd0, b}, s));
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic wait32(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (done32 !== 1'b1 && cyc < 200) begin
      if (busy32 !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start32 = 0; sop32 = 0; a32 = 0; b32 = 0;
    start8 = 0; sop8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy32); end
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done32); end
    total++; if (dz32 !== 1'b0) begin bad++; $display("FAIL reset_divzero got=%b exp=0", dz32); end
    total++; if (hi32 !== 32'd0 || lo32 !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi32, lo32); end
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0 || lo8 !== 8'd0) begin bad++; $display("FAIL reset_w8 got=%b%b%h exp=000", busy8, done8, lo8); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int cyc; bit bok; exp_t e;
    issue32(32'd100, 32'd7, 1'b0);
    wait32(cyc, bok);
    total++; if (cyc != 34) begin bad++; $display("FAIL unsigned_latency got=%0d exp=34", cyc); end
    total++; if (!bok) begin bad++; $display("FAIL unsigned_busy got=low exp=high in cycles 1..33"); end
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL unsigned_busy_done got=%b exp=0", busy32); end
    e = sbq.pop_front();
    total++; if (lo32 !== e.lo[31:0] || hi32 !== e.hi[31:0]) begin bad++; $display("FAIL unsigned_100_7 got=%h/%h exp=%h/%h", lo32, hi32, e.lo[31:0], e.hi[31:0]); end
    @(negedge clk);
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done32); end
  endtask

  task automatic test_signed();
    logic [31:0] ta[5] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'h80000000, 32'hFFFFFF9C};
    logic [31:0] tb[5] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007};
    logic        ts[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int cyc; bit bok; exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue32(ta[i], tb[i], ts[i]);
      wait32(cyc, bok);
      total++; if (cyc != 34) begin bad++; $display("FAIL signed_latency[%0d] got=%0d exp=34", i, cyc); end
      e = sbq.pop_front();
      total++; if (lo32 !== e.lo[31:0] || hi32 !== e.hi[31:0]) begin bad++; $display("FAIL signed_result[%0d] got=%h/%h exp=%h/%h", i, lo32, hi32, e.lo[31:0], e.hi[31:0]); end
    end
  endtask

  task automatic test_divzero();
    int cyc; bit bok; exp_t e;
    issue32(32'd100, 32'd7, 1'b0);
    wait32(cyc, bok);
    e = sbq.pop_front();
    issue32(32'd55, 32'd0, 1'b0);
    total++; if (done32 !== 1'b1 || dz32 !== 1'b1) begin bad++; $display("FAIL divzero_flag got=done%b dz%b exp=done1 dz1", done32, dz32); end
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL divzero_busy got=%b exp=0", busy32); end
    total++; if (lo32 !== 32'd14 || hi32 !== 32'd2) begin bad++; $display("FAIL divzero_hold got=%h/%h exp=0000000e/00000002", lo32, hi32); end
    @(negedge clk);
    total++; if (done32 !== 1'b0 || dz32 !== 1'b1) begin bad++; $display("FAIL divzero_sticky got=done%b dz%b exp=done0 dz1", done32, dz32); end
    issue32(32'd9, 32'd4, 1'b0);
    total++; if (dz32 !== 1'b0) begin bad++; $display("FAIL divzero_clear got=%b exp=0", dz32); end
    wait32(cyc, bok);
    e = sbq.pop_front();
    total++; if (cyc != 34 || lo32 !== e.lo[31:0] || hi32 !== e.hi[31:0]) begin bad++; $display("FAIL after_divzero got=%0d %h/%h exp=34 %h/%h", cyc, lo32, hi32, e.lo[31:0], e.hi[31:0]); end
  endtask

  task automatic test_ignore_start();
    int cyc; exp_t e;
    issue32(32'd100, 32'd7, 1'b0);
    cyc = 1;
    while (done32 !== 1'b1 && cyc < 200) begin
      if (cyc == 10) begin a32 = 32'd55; b32 = 32'd5; start32 = 1'b1; end
      else start32 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start32 = 1'b0;
    e = sbq.pop_front();
    total++; if (cyc != 34) begin bad++; $display("FAIL ignore_latency got=%0d exp=34", cyc); end
    total++; if (lo32 !== e.lo[31:0] || hi32 !== e.hi[31:0]) begin bad++; $display("FAIL ignore_result got=%h/%h exp=%h/%h", lo32, hi32, e.lo[31:0], e.hi[31:0]); end
    @(negedge clk);
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got=%b exp=0", busy32); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    issue32(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (busy32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin bad++; $display("FAIL async_reset got=busy%b %h/%h exp=busy0 0/0", busy32, hi32, lo32); end
    void'(sbq.pop_front());
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (done32 === 1'b1) saw_done = 1'b1; end
    reset = 1'b1;
    repeat (40) begin @(negedge clk); if (done32 === 1'b1 || busy32 === 1'b1) saw_done = 1'b1; end
    total++; if (saw_done) begin bad++; $display("FAIL reset_abandon got=activity exp=idle"); end
  endtask

  task automatic test_width8_back_to_back();
    int cyc; exp_t e;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd3; sop8 = 1'b0; start8 = 1'b1;
    sbq.push_back(model(8, 64'd200, 64'd3, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      e = sbq.pop_front();
      total++; if (cyc != 10) begin bad++; $display("FAIL w8_latency[%0d] got=%0d exp=10", k, cyc); end
      total++; if (lo8 !== e.lo[7:0] || hi8 !== e.hi[7:0]) begin bad++; $display("FAIL w8_result[%0d] got=%h/%h exp=%h/%h", k, lo8, hi8, e.lo[7:0], e.hi[7:0]); end
      if (k == 0) begin
        a8 = 8'h9C; b8 = 8'd7; sop8 = 1'b1; start8 = 1'b1;
        sbq.push_back(model(8, 64'h9C, 64'd7, 1'b1));
        @(negedge clk);
        start8 = 1'b0;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL w8_back_to_back got=busy%b exp=busy1", busy8); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_ignore_start();
    test_reset_mid();
    test_width8_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
